// File: rtl/fe_pkg.sv
// Shared front-end types: RV32I major opcodes, control-unit states and an
// opcode classifier used by the multi-cycle sequencer.
package fe_pkg;

    typedef enum logic [6:0] {
        R_TYPE      = 7'b0110011,
        I_TYPE      = 7'b0010011,
        I_LOAD_TYPE = 7'b0000011,
        I_JALR_TYPE = 7'b1100111,
        S_TYPE      = 7'b0100011,
        B_TYPE      = 7'b1100011,
        U_LUI_TYPE  = 7'b0110111,
        U_AUI_TYPE  = 7'b0010111,
        J_TYPE      = 7'b1101111
    } RV32I_OPCODE_t;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        FAULT
    } cu_state_t;

    typedef enum logic [2:0] {
        OPC_WB,
        OPC_LOAD,
        OPC_STORE,
        OPC_BRANCH,
        OPC_ILLEGAL
    } op_class_t;

    function automatic op_class_t classify(RV32I_OPCODE_t op);
        case (op)
            I_LOAD_TYPE: return OPC_LOAD;
            S_TYPE:      return OPC_STORE;
            B_TYPE:      return OPC_BRANCH;
            R_TYPE, I_TYPE, U_LUI_TYPE, U_AUI_TYPE,
            J_TYPE, I_JALR_TYPE: return OPC_WB;
            default:     return OPC_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/bus_wait_timer.sv
// Counts consecutive unanswered bus-request cycles; expired flags the last
// permissible wait cycle so the sequencer can fault on it.
module bus_wait_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear)
            count <= '0;
        else if (count_en)
            count <= count + CNT_W'(1);
    end

    always_comb expired = (count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXEC/MEM/WB over a shared
// ready-handshake bus, with bus-wait timeout, sticky fault and retire counter.
module multicycle_control_unit
    import fe_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned RETIRE_CNT_W   = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  RV32I_OPCODE_t           opcode,
    input  logic                    bus_ready,
    input  logic                    halt,
    output logic                    bus_rden,
    output logic                    bus_wren,
    output logic                    bus_ifetch,
    output logic                    ir_wren,
    output logic                    pc_wren,
    output logic                    rf_wren,
    output logic                    bus_fault,
    output logic [RETIRE_CNT_W-1:0] retired_count,
    output cu_state_t               state
);

    op_class_t op_class;
    logic      req_active;
    logic      expired;

    always_comb begin
        op_class   = classify(opcode);
        req_active = ((state == FETCH) && !halt) || (state == MEM);
    end

    // Clearing whenever no request is pending gives a zero count on every
    // entry to FETCH or MEM without tracking the transitions explicitly.
    bus_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (!req_active || bus_ready),
        .count_en(req_active && !bus_ready),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            case (state)
                FETCH: begin
                    if (!halt) begin
                        if (bus_ready)    state <= DECODE;
                        else if (expired) state <= FAULT;
                    end
                end
                DECODE: state <= EXEC;
                EXEC: begin
                    case (op_class)
                        OPC_LOAD, OPC_STORE: state <= MEM;
                        OPC_BRANCH:          state <= FETCH;
                        OPC_WB:              state <= WB;
                        default:             state <= FAULT;
                    endcase
                end
                MEM: begin
                    if (bus_ready)    state <= (op_class == OPC_STORE) ? FETCH : WB;
                    else if (expired) state <= FAULT;
                end
                WB:      state <= FETCH;
                default: state <= FAULT;
            endcase
        end
    end

    always_comb begin
        bus_rden   = 1'b0;
        bus_wren   = 1'b0;
        bus_ifetch = 1'b0;
        ir_wren    = 1'b0;
        pc_wren    = 1'b0;
        rf_wren    = 1'b0;
        if (!rst) begin
            case (state)
                FETCH: begin
                    if (!halt) begin
                        bus_rden   = 1'b1;
                        bus_ifetch = 1'b1;
                        ir_wren    = bus_ready;
                    end
                end
                EXEC: pc_wren = (op_class == OPC_BRANCH);
                MEM: begin
                    if (op_class == OPC_STORE) begin
                        bus_wren = 1'b1;
                        pc_wren  = bus_ready;
                    end else begin
                        bus_rden = 1'b1;
                    end
                end
                WB: begin
                    rf_wren = 1'b1;
                    pc_wren = 1'b1;
                end
                default: ;
            endcase
        end
        bus_fault = (state == FAULT);
    end

    always_ff @(posedge clk) begin
        if (rst)
            retired_count <= '0;
        else if (pc_wren)
            retired_count <= retired_count + RETIRE_CNT_W'(1);
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: directed vector table, hand-built corner
// sequences and random instruction streams expanded by a transaction model.
module tb_multicycle_control_unit;
    import fe_pkg::*;

    typedef struct {
        logic          rdy;
        logic          hlt;
        RV32I_OPCODE_t op;
        logic [5:0]    strb;   // {rden, wren, ifetch, ir, pc, rf}
        logic          flt;
        cu_state_t     st;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    RV32I_OPCODE_t opcode = R_TYPE;
    logic          bus_ready = 1'b0;
    logic          halt = 1'b0;
    logic          bus_rden, bus_wren, bus_ifetch, ir_wren, pc_wren, rf_wren, bus_fault;
    logic [3:0]    retired_count;
    cu_state_t     state;

    int unsigned   n_vec = 0;
    int unsigned   n_bad = 0;
    logic [3:0]    exp_ret = '0;
    vec_t          q[$];
    vec_t          tbl[16];

    always #5 clk = ~clk;

    multicycle_control_unit #(
        .TIMEOUT_CYCLES(4),
        .RETIRE_CNT_W  (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .opcode       (opcode),
        .bus_ready    (bus_ready),
        .halt         (halt),
        .bus_rden     (bus_rden),
        .bus_wren     (bus_wren),
        .bus_ifetch   (bus_ifetch),
        .ir_wren      (ir_wren),
        .pc_wren      (pc_wren),
        .rf_wren      (rf_wren),
        .bus_fault    (bus_fault),
        .retired_count(retired_count),
        .state        (state)
    );

    function automatic vec_t mk(logic rdy, logic hlt, RV32I_OPCODE_t op, logic [5:0] s, cu_state_t st);
        vec_t v;
        v.rdy = rdy; v.hlt = hlt; v.op = op; v.strb = s; v.st = st;
        v.flt = (st == FAULT);
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Entered and left at a falling edge; outputs checked 1 time unit later.
    task automatic apply(vec_t v);
        bus_ready = v.rdy;
        halt      = v.hlt;
        opcode    = v.op;
        #1;
        chk("strobes", 32'({bus_rden, bus_wren, bus_ifetch, ir_wren, pc_wren, rf_wren}), 32'(v.strb));
        chk("bus_fault", 32'(bus_fault), 32'(v.flt));
        chk("state", 32'(state), 32'(v.st));
        chk("retired_count", 32'(retired_count), 32'(exp_ret));
        if (v.strb[1]) exp_ret = exp_ret + 4'd1;
        @(negedge clk);
    endtask

    task automatic run_q();
        while (q.size() > 0) apply(q.pop_front());
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        bus_ready = 1'($urandom_range(0, 1));
        halt      = 1'b0;
        #1;
        chk("strobes_in_reset", 32'({bus_rden, bus_wren, bus_ifetch, ir_wren, pc_wren, rf_wren}), 32'd0);
        @(negedge clk);
        rst     = 1'b0;
        exp_ret = '0;
    endtask

    // Expands one instruction into its expected cycle sequence; returns 1 if it faults.
    function automatic bit gen(RV32I_OPCODE_t op, int hn, int fw, int mw);
        bit is_st = (op == S_TYPE);
        bit is_mem = op inside {I_LOAD_TYPE, S_TYPE};
        bit is_wb  = op inside {R_TYPE, I_TYPE, U_LUI_TYPE, U_AUI_TYPE, J_TYPE, I_JALR_TYPE};
        logic [5:0] ms = is_st ? 6'b010000 : 6'b100000;
        for (int i = 0; i < hn; i++) q.push_back(mk(1'($urandom_range(0, 1)), 1'b1, op, 6'b000000, FETCH));
        for (int i = 0; i < fw; i++) q.push_back(mk(1'b0, 1'b0, op, 6'b101000, FETCH));
        q.push_back(mk(1'b1, 1'b0, op, 6'b101100, FETCH));
        q.push_back(mk(1'($urandom_range(0, 1)), 1'b0, op, 6'b000000, DECODE));
        if (op == B_TYPE) begin
            q.push_back(mk(1'($urandom_range(0, 1)), 1'b0, op, 6'b000010, EXEC));
            return 0;
        end
        q.push_back(mk(1'($urandom_range(0, 1)), 1'b0, op, 6'b000000, EXEC));
        if (!is_mem && !is_wb) begin
            q.push_back(mk(1'b1, 1'b0, op, 6'b000000, FAULT));
            return 1;
        end
        if (is_mem) begin
            for (int i = 0; i < mw && i < 4; i++) q.push_back(mk(1'b0, 1'b0, op, ms, MEM));
            if (mw >= 4) begin
                q.push_back(mk(1'b1, 1'b0, op, 6'b000000, FAULT));
                return 1;
            end
            q.push_back(mk(1'b1, 1'b0, op, is_st ? 6'b010010 : 6'b100000, MEM));
            if (is_st) return 0;
        end
        q.push_back(mk(1'($urandom_range(0, 1)), 1'b0, op, 6'b000011, WB));
        return 0;
    endfunction

    initial begin
        RV32I_OPCODE_t legal[9];
        bit f;
        legal = '{R_TYPE, I_TYPE, I_LOAD_TYPE, I_JALR_TYPE, S_TYPE, B_TYPE, U_LUI_TYPE, U_AUI_TYPE, J_TYPE};

        tbl[0]  = mk(1, 0, R_TYPE, 6'b101100, FETCH);
        tbl[1]  = mk(0, 0, R_TYPE, 6'b000000, DECODE);
        tbl[2]  = mk(1, 0, R_TYPE, 6'b000000, EXEC);
        tbl[3]  = mk(0, 0, R_TYPE, 6'b000011, WB);
        tbl[4]  = mk(1, 0, S_TYPE, 6'b101100, FETCH);
        tbl[5]  = mk(1, 0, S_TYPE, 6'b000000, DECODE);
        tbl[6]  = mk(1, 0, S_TYPE, 6'b000000, EXEC);
        tbl[7]  = mk(1, 0, S_TYPE, 6'b010010, MEM);
        tbl[8]  = mk(1, 0, I_LOAD_TYPE, 6'b101100, FETCH);
        tbl[9]  = mk(0, 0, I_LOAD_TYPE, 6'b000000, DECODE);
        tbl[10] = mk(0, 0, I_LOAD_TYPE, 6'b000000, EXEC);
        tbl[11] = mk(0, 0, I_LOAD_TYPE, 6'b100000, MEM);
        tbl[12] = mk(0, 0, I_LOAD_TYPE, 6'b100000, MEM);
        tbl[13] = mk(0, 0, I_LOAD_TYPE, 6'b100000, MEM);
        tbl[14] = mk(1, 0, I_LOAD_TYPE, 6'b100000, MEM);
        tbl[15] = mk(0, 0, I_LOAD_TYPE, 6'b000011, WB);

        @(negedge clk);
        do_reset();
        for (int i = 0; i < 16; i++) apply(tbl[i]);

        // Fetch timeout: four unanswered request cycles, then sticky fault.
        for (int i = 0; i < 4; i++) q.push_back(mk(1'b0, 1'b0, R_TYPE, 6'b101000, FETCH));
        for (int i = 0; i < 3; i++) q.push_back(mk(1'b1, 1'b0, R_TYPE, 6'b000000, FAULT));
        run_q();
        do_reset();
        f = gen(R_TYPE, 0, 3, 0);
        run_q();

        // Store timeout in MEM, then illegal opcode.
        f = gen(S_TYPE, 0, 0, 4);
        run_q();
        do_reset();
        f = gen(RV32I_OPCODE_t'(7'h7F), 0, 1, 0);
        q.push_back(mk(1'b1, 1'b0, R_TYPE, 6'b000000, FAULT));
        run_q();
        do_reset();

        // Halt for five cycles, then reset abandoning a load mid-MEM.
        f = gen(J_TYPE, 5, 0, 0);
        run_q();
        f = gen(I_LOAD_TYPE, 0, 0, 3);
        repeat (4) apply(q.pop_front());
        q.delete();
        do_reset();

        // Sixteen retirements wrap the 4-bit counter back to zero.
        for (int i = 0; i < 16; i++) f = gen(B_TYPE, 0, 0, 0);
        run_q();
        #1 chk("retire_wrap", 32'(retired_count), 32'd0);
        @(negedge clk);
        do_reset();

        for (int n = 0; n < 80; n++) begin
            RV32I_OPCODE_t op = legal[$urandom_range(0, 8)];
            int hn = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            int mw = ($urandom_range(0, 15) == 0) ? 4 : int'($urandom_range(0, 3));
            f = gen(op, hn, int'($urandom_range(0, 3)), mw);
            run_q();
            if (f) do_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Multi-cycle successor to the single-cycle front-end control unit: a state machine sequencing each RV32I instruction through fetch, decode, execute, memory and writeback over a shared bus with a ready handshake. Sits in `fe`, driving the IR/PC/register-file write enables and bus strobes from `opcode` (`RV32I_OPCODE_t`). Adds a parametrised bus-wait timeout with a sticky fault, a halt input and a retired-instruction counter.

## Interface
- `TIMEOUT_CYCLES`, 16: max consecutive cycles a bus request waits for `bus_ready` before faulting; legal 2..1024.
- `RETIRE_CNT_W`, 32: width of `retired_count`.

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `opcode`  in  `RV32I_OPCODE_t`  opcode field of the current IR; valid from DECODE onward.
- `bus_ready`  in  1  bus completes the current read/write this cycle.
- `halt`  in  1  when high in FETCH, no new fetch is issued.
- `bus_rden`  out  1  bus read strobe (instruction fetch or load).
- `bus_wren`  out  1  bus write strobe (store).
- `bus_ifetch`  out  1  bus address is the PC (high in FETCH only).
- `ir_wren`  out  1  load IR from bus read data.
- `pc_wren`  out  1  update PC; marks instruction retirement.
- `rf_wren`  out  1  register file write enable.
- `bus_fault`  out  1  sticky fault indicator.
- `retired_count`  out  `RETIRE_CNT_W`  retired instruction count, wraps.
- `state`  out  `cu_state_t`  current FSM state, for debug.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, FAULT.
- FETCH: if `halt`, stay with all strobes low and the wait counter held at 0. Otherwise `bus_rden`=`bus_ifetch`=1; on `bus_ready`, `ir_wren`=1 and go to DECODE.
- DECODE: one cycle, no strobes, then EXEC.
- EXEC, by `opcode`:
  - I_LOAD_TYPE or S_TYPE -> MEM.
  - B_TYPE -> `pc_wren`=1, then FETCH.
  - R_TYPE, I_TYPE, U_LUI_TYPE, U_AUI_TYPE, J_TYPE, I_JALR_TYPE -> WB.
  - Any other encoding -> FAULT, with no `pc_wren` that cycle.
- MEM, load: `bus_rden`=1 until `bus_ready`, then WB.
- MEM, store: `bus_wren`=1 until `bus_ready`; the ready cycle also asserts `pc_wren`=1, then FETCH.
- WB: `rf_wren`=1 and `pc_wren`=1, then FETCH.
- Wait counter: cleared on entry to FETCH or MEM. Increments on each cycle a request is held without `bus_ready`. If the count equals `TIMEOUT_CYCLES-1` and `bus_ready`=0, go to FAULT. `bus_ready` on that same cycle wins, giving a normal completion.
- FAULT: all strobes low, `bus_fault`=1, exited only by `rst`.
- `retired_count` increments by 1 on every cycle with `pc_wren`=1 and wraps from all-ones to 0.

## Timing
- Reset: `state`=FETCH, wait counter 0, `retired_count`=0, `bus_fault`=0.
- While `rst` is high, every strobe (`bus_rden`, `bus_wren`, `bus_ifetch`, `ir_wren`, `pc_wren`, `rf_wren`) is forced 0.
- Reset mid-instruction (any state, including FAULT) abandons the instruction. FETCH is issued on the first cycle after `rst` falls.
- Strobes are combinational from `state`, `opcode` and `bus_ready` (Moore, plus ready-qualified `ir_wren` and store `pc_wren`). There is no register stage on outputs.
- Latency with `bus_ready` tied high:
  - ALU, U and J types: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch: 3 cycles.
- Each bus wait cycle adds 1 cycle to the instruction.
- `bus_ready` is ignored in DECODE, EXEC, WB and FAULT.
- `halt` is sampled only in FETCH; it never interrupts an instruction already in progress.

## Structure
- `cu_state_t` enum goes in `fe_pkg`. B_TYPE sits alongside the other `RV32I_OPCODE_t` members in the shared package.
- Wait counter is the sub-module `bus_wait_timer`, parametrised by `TIMEOUT_CYCLES`. Interface: clear, count-enable, `expired`. Counter width is `$clog2(TIMEOUT_CYCLES)`.
- FSM, output decode and retire counter stay in `multicycle_control_unit`.

## Test plan
- R_TYPE with `bus_ready`=1: FETCH to WB in 4 cycles; `rf_wren` and `pc_wren` high only in the WB cycle; `retired_count` goes 0 -> 1.
- I_LOAD_TYPE with `bus_ready` delayed 3 cycles in MEM: `bus_rden` held 4 cycles in MEM, then WB writes; total 8 cycles.
- S_TYPE with ready on the first MEM cycle: `bus_wren`=1 and `pc_wren`=1 in the same cycle, `rf_wren` never high; next state FETCH.
- `TIMEOUT_CYCLES`=4, `bus_ready` held 0 in FETCH: FAULT entered after 4 request cycles, `bus_fault`=1 and sticky. A second run with ready on the 4th cycle completes normally.
- Illegal opcode in EXEC -> FAULT, no `pc_wren`. `rst` pulse clears `bus_fault`, state returns to FETCH, `retired_count`=0.
- `halt`=1 in FETCH for 5 cycles: no strobes; fetch issues on the cycle `halt` drops. With `RETIRE_CNT_W`=4, 16 retirements wrap `retired_count` to 0.
